// File: rtl/open_file_struct_streamer.sv
// Streams the "open file" request struct (NUL-padded path, flags, big-endian size)
// as bus-width words, fetching path bytes from a 1-cycle-latency path RAM.
module open_file_struct_streamer #(
    parameter int PATH_BYTES = 256,
    parameter int WORD_BYTES = 4
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            start,
    input  logic [31:0]                                     file_size,
    input  logic                                            create_en,
    input  logic                                            resize_en,
    output logic [$clog2(PATH_BYTES)-1:0]                   path_addr,
    input  logic [7:0]                                      path_char,
    output logic                                            wr_valid,
    input  logic                                            wr_ready,
    output logic [$clog2((PATH_BYTES+8)/WORD_BYTES)-1:0]    wr_addr,
    output logic [8*WORD_BYTES-1:0]                         wr_data,
    output logic                                            busy,
    output logic                                            done
);
    localparam int STRUCT_BYTES = PATH_BYTES + 8;
    localparam int NUM_WORDS    = STRUCT_BYTES / WORD_BYTES;
    localparam int PATH_WORDS   = PATH_BYTES / WORD_BYTES;
    localparam int TRAIL_WORDS  = 8 / WORD_BYTES;
    localparam int AW           = $clog2(PATH_BYTES);
    localparam int WW           = $clog2(NUM_WORDS);
    localparam int DW           = 8 * WORD_BYTES;
    localparam int TW           = (TRAIL_WORDS > 1) ? $clog2(TRAIL_WORDS) : 1;

    localparam logic [WW-1:0] LAST_WORD      = WW'(NUM_WORDS - 1);
    localparam logic [WW-1:0] LAST_PATH_WORD = WW'(PATH_WORDS - 1);
    localparam logic [WW-1:0] FIRST_TRAILER  = WW'(PATH_WORDS);
    localparam logic [3:0]    FETCH_LAST     = 4'(WORD_BYTES);

    typedef enum logic [2:0] {IDLE, FETCH, BUILD, PRESENT, DONE} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [WW-1:0]   word_reg;
    logic [3:0]      cnt_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   data_reg;
    logic            nul_seen_reg;
    logic [31:0]     size_reg;
    logic [1:0]      flags_reg;

    logic [63:0]     trailer;
    logic [DW-1:0]   trailer_word [TRAIL_WORDS];
    logic [TW-1:0]   trailer_idx;
    logic [7:0]      path_byte;

    assign trailer     = {24'd0, 6'd0, flags_reg, size_reg};
    assign trailer_idx = TW'(word_reg - FIRST_TRAILER);
    assign path_byte   = (nul_seen_reg || path_char == 8'h00) ? 8'h00 : path_char;

    generate
        for (genvar gi = 0; gi < TRAIL_WORDS; gi++) begin : g_trailer
            assign trailer_word[gi] = trailer[63 - gi*DW -: DW];
        end
    endgenerate

    assign path_addr = addr_reg;
    assign wr_addr   = word_reg;
    assign wr_data   = data_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (cnt_reg == FETCH_LAST) state_next = PRESENT;
            end
            BUILD: begin
                busy       = 1'b1;
                state_next = PRESENT;
            end
            PRESENT: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                if (wr_ready) begin
                    if (word_reg == LAST_WORD)           state_next = DONE;
                    else if (word_reg < LAST_PATH_WORD)  state_next = FETCH;
                    else                                 state_next = BUILD;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Fetch pipeline: address for byte k is driven in cycle k, its data captured in cycle k+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_reg     <= '0;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            nul_seen_reg <= 1'b0;
            size_reg     <= '0;
            flags_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        word_reg     <= '0;
                        cnt_reg      <= '0;
                        addr_reg     <= '0;
                        nul_seen_reg <= 1'b0;
                        size_reg     <= file_size;
                        flags_reg    <= {resize_en, create_en};
                    end
                end
                FETCH: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg < FETCH_LAST - 4'd1) addr_reg <= addr_reg + AW'(1);
                    if (cnt_reg != 4'd0) begin
                        data_reg <= DW'({data_reg, path_byte});
                        if (path_char == 8'h00) nul_seen_reg <= 1'b1;
                    end
                end
                BUILD: begin
                    data_reg <= trailer_word[trailer_idx];
                end
                PRESENT: begin
                    if (wr_ready) begin
                        cnt_reg <= '0;
                        if (word_reg != LAST_WORD) begin
                            word_reg <= word_reg + WW'(1);
                            if (word_reg < LAST_PATH_WORD) addr_reg <= addr_reg + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_open_file_struct_streamer.sv
// Randomised bench for open_file_struct_streamer: a 4-byte-word and a 1-byte-word instance
// are checked against a byte-level model of the struct layout and the handshake timing.
module tb_open_file_struct_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start_a, start_b, create_en, resize_en, wr_ready;
    logic [31:0] file_size;
    logic [7:0]  path_addr_a, path_addr_b, path_char_a, path_char_b;
    logic        wr_valid_a, busy_a, done_a, wr_valid_b, busy_b, done_b;
    logic [6:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic [8:0]  wr_addr_b;
    logic [7:0]  wr_data_b;
    logic [7:0]  path_mem [256];

    open_file_struct_streamer #(.PATH_BYTES(256), .WORD_BYTES(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .file_size(file_size),
        .create_en(create_en), .resize_en(resize_en), .path_addr(path_addr_a),
        .path_char(path_char_a), .wr_valid(wr_valid_a), .wr_ready(wr_ready),
        .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a), .done(done_a));

    open_file_struct_streamer #(.PATH_BYTES(256), .WORD_BYTES(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .file_size(file_size),
        .create_en(create_en), .resize_en(resize_en), .path_addr(path_addr_b),
        .path_char(path_char_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b), .done(done_b));

    always @(posedge clk) begin
        path_char_a <= path_mem[path_addr_a];
        path_char_b <= path_mem[path_addr_b];
    end

    bit          sel;
    logic        obs_valid, obs_busy, obs_done;
    logic [8:0]  obs_addr;
    logic [31:0] obs_data;
    assign obs_valid = sel ? wr_valid_b : wr_valid_a;
    assign obs_busy  = sel ? busy_b : busy_a;
    assign obs_done  = sel ? done_b : done_a;
    assign obs_addr  = sel ? wr_addr_b : {2'b00, wr_addr_a};
    assign obs_data  = sel ? {24'd0, wr_data_b} : wr_data_a;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: the struct as a flat byte list.
    logic [7:0]  exp_bytes [$];
    logic [31:0] ref_size;
    logic        ref_create, ref_resize;
    logic [8:0]  got_addr [$];
    logic [31:0] got_data [$];

    function automatic void build_expected();
        bit nul = 1'b0;
        exp_bytes.delete();
        for (int b = 0; b < 256; b++) begin
            if (path_mem[b] == 8'h00) nul = 1'b1;
            exp_bytes.push_back(nul ? 8'h00 : path_mem[b]);
        end
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back({6'd0, ref_resize, ref_create});
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(8'(ref_size >> (8*i)));
    endfunction

    function automatic logic [31:0] exp_word(input int w, input int wb);
        logic [31:0] v = 32'd0;
        for (int j = 0; j < wb; j++) v = (v << 8) | 32'(exp_bytes[w*wb + j]);
        return v;
    endfunction

    task automatic fill_random_path(input int nul_pos);
        for (int b = 0; b < 256; b++) path_mem[b] = 8'($urandom_range(255, 1));
        if (nul_pos >= 0 && nul_pos < 256) path_mem[nul_pos] = 8'h00;
    endtask

    task automatic run_struct(input bit use_b, input int ready_pct, input bit poke, input int abort_word);
        int  wb      = use_b ? 1 : 4;
        int  nwords  = use_b ? 264 : 66;
        int  pwords  = use_b ? 256 : 64;
        int  cyc     = 0;
        int  last_hs = 0;
        int  n       = 0;
        bit  waiting = 1'b1;
        bit  stalled = 1'b0;
        bit  finished = 1'b0;
        logic [8:0]  st_addr = '0;
        logic [31:0] st_data = '0;
        sel = use_b;
        got_addr.delete();
        got_data.delete();
        build_expected();
        @(negedge clk);
        #1;
        check_eq("idle_done", 32'(obs_done), 32'd0);
        check_eq("idle_busy", 32'(obs_busy), 32'd0);
        file_size = ref_size;
        create_en = ref_create;
        resize_en = ref_resize;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (cyc == 1) begin
                file_size = $urandom;
                create_en = 1'($urandom);
                resize_en = 1'($urandom);
            end
            wr_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (cyc == 1) check_eq("busy_after_start", 32'(obs_busy), 32'd1);
            if (obs_done) begin
                check_eq("done_timing", cyc, last_hs + 1);
                check_eq("done_busy", 32'(obs_busy), 32'd0);
                check_eq("done_word_count", n, nwords);
                finished = 1'b1;
            end else if (obs_valid) begin
                if (waiting) begin
                    check_eq($sformatf("latency_w%0d", n), cyc - last_hs, (n < pwords) ? wb + 2 : 2);
                    waiting = 1'b0;
                    if (poke && n == 10) begin
                        file_size = 32'hAAAAAAAA;
                        if (use_b) start_b = 1'b1; else start_a = 1'b1;
                    end
                    if (abort_word == n) begin
                        reset_n = 1'b0;
                        #1;
                        check_eq("rst_valid", 32'(obs_valid), 32'd0);
                        check_eq("rst_busy", 32'(obs_busy), 32'd0);
                        check_eq("rst_addr", 32'(obs_addr), 32'd0);
                        check_eq("rst_data", obs_data, 32'd0);
                        check_eq("rst_path_addr", 32'(use_b ? path_addr_b : path_addr_a), 32'd0);
                        repeat (2) @(negedge clk);
                        reset_n = 1'b1;
                        return;
                    end
                end else if (stalled) begin
                    check_eq("stall_addr", 32'(obs_addr), 32'(st_addr));
                    check_eq("stall_data", obs_data, st_data);
                end
                if (wr_ready) begin
                    got_addr.push_back(obs_addr);
                    got_data.push_back(obs_data);
                    n++;
                    last_hs = cyc;
                    waiting = 1'b1;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    st_addr = obs_addr;
                    st_data = obs_data;
                end
            end
            if (!finished && cyc > 4000) begin
                check_eq("timeout", 32'd0, 32'd1);
                finished = 1'b1;
            end
        end
        check_eq("num_words", got_addr.size(), nwords);
        for (int i = 0; i < got_addr.size() && i < nwords; i++) begin
            check_eq($sformatf("addr_%0d", i), 32'(got_addr[i]), i);
            check_eq($sformatf("word_%0d", i), got_data[i], exp_word(i, wb));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        wr_ready  = 1'b0;
        file_size = '0;
        create_en = 1'b0;
        resize_en = 1'b0;
        sel       = 1'b0;
        for (int b = 0; b < 256; b++) path_mem[b] = 8'hFF;
        path_mem[0] = 8'h61;
        path_mem[1] = 8'h62;
        path_mem[2] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_valid_a", 32'(wr_valid_a), 32'd0);
        check_eq("reset_busy_a", 32'(busy_a), 32'd0);
        check_eq("reset_done_a", 32'(done_a), 32'd0);
        check_eq("reset_addr_a", 32'(wr_addr_a), 32'd0);
        check_eq("reset_data_a", wr_data_a, 32'd0);
        check_eq("reset_path_addr_a", 32'(path_addr_a), 32'd0);
        check_eq("reset_valid_b", 32'(wr_valid_b), 32'd0);
        check_eq("reset_busy_b", 32'(busy_b), 32'd0);
        reset_n = 1'b1;

        ref_size   = 32'h12345678;
        ref_create = 1'b1;
        ref_resize = 1'b1;
        run_struct(1'b0, 100, 1'b0, -1);
        check_eq("spec_w0", got_data[0], 32'h61620000);
        check_eq("spec_w1", got_data[1], 32'h00000000);
        check_eq("spec_w64", got_data[64], 32'h00000003);
        check_eq("spec_w65", got_data[65], 32'h12345678);

        run_struct(1'b0, 50, 1'b0, -1);
        run_struct(1'b0, 100, 1'b1, -1);
        check_eq("poke_w65", got_data[65], 32'h12345678);

        run_struct(1'b0, 50, 1'b0, 20);
        fill_random_path(-1);
        ref_size   = $urandom;
        ref_create = 1'b0;
        ref_resize = 1'b1;
        run_struct(1'b0, 60, 1'b0, -1);
        check_eq("after_rst_w0", got_data[0],
                 {path_mem[0], path_mem[1], path_mem[2], path_mem[3]});

        fill_random_path(int'($urandom_range(255)));
        ref_size   = $urandom;
        ref_create = 1'($urandom);
        ref_resize = 1'($urandom);
        run_struct(1'b0, 70, 1'b0, -1);
        fill_random_path(int'($urandom_range(300)));
        ref_size   = $urandom;
        ref_create = 1'($urandom);
        ref_resize = 1'($urandom);
        run_struct(1'b0, 40, 1'b0, -1);

        for (int b = 0; b < 256; b++) path_mem[b] = 8'(b);
        path_mem[0] = 8'h2F;
        ref_size   = 32'h00000400;
        ref_create = 1'b0;
        ref_resize = 1'b1;
        run_struct(1'b1, 100, 1'b0, -1);
        check_eq("b_addr_0ff", got_data[255], 32'h000000FF);
        check_eq("b_addr_103", got_data[259], 32'h00000002);
        check_eq("b_addr_106", got_data[262], 32'h00000004);
        check_eq("b_addr_107", got_data[263], 32'h00000000);

        fill_random_path(int'($urandom_range(255)));
        ref_size   = $urandom;
        ref_create = 1'b1;
        ref_resize = 1'b0;
        run_struct(1'b1, 50, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
